// File: rtl/latch_event_sync_pkg.sv
// Shared types and defaults for the latch event synchroniser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package latch_event_sync_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_QUAL_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_QUAL_LO = 2'd3
    } state_t;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: STAGES clock edges from a stable input to q.
// Backpressure: none; free-running shift chain.
//
// Ports: clk, rst_n (async active-low, clears chain to 0), d (async level in),
//        q (synchronised level out).
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/latch_event_sync.sv
// Synchronise and glitch-filter a latch level, pulse on edges, publish counted edge records.
// Latency: rise/fall pulse and record appear after edge SYNC_STAGES+FILTER_CYCLES-1.
// Backpressure: one-deep record register; an event arriving while it is full is dropped and flagged.
//
// Ports: clk, rst_n (async active-low); d_in (async level from latch);
//        level_out, rise_pulse, fall_pulse (filtered level and edge strobes);
//        evt_valid/evt_ready handshake carrying evt_edge (1=rise) and evt_count;
//        overflow (sticky, set when a record is dropped, cleared only by reset).
// Build option: define LATCH_EVENT_SYNC_FALL_EVT_EN to also record falling edges.
module latch_event_sync
    import latch_event_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_edge,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow
);

    // Qualification completes when qcnt reaches this value on a further matching sample.
    localparam logic [3:0] QMAX      = 4'(FILTER_CYCLES - 1);
    localparam bit         NO_FILTER = (FILTER_CYCLES == 1);

    logic s_lvl;

    sync_ff_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d_in),
        .q    (s_lvl)
    );

    state_t     state_q, state_d;
    logic [3:0] qcnt_q, qcnt_d;
    logic       rise_fire, fall_fire;

    // Edge qualification FSM
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        rise_fire = 1'b0;
        fall_fire = 1'b0;
        case (state_q)
            S_LOW: begin
                if (s_lvl) begin
                    if (NO_FILTER) begin
                        state_d   = S_HIGH;
                        rise_fire = 1'b1;
                    end else begin
                        state_d = S_QUAL_HI;
                        qcnt_d  = 4'd1;
                    end
                end
            end
            S_QUAL_HI: begin
                if (!s_lvl) begin
                    state_d = S_LOW;
                    qcnt_d  = 4'd0;
                end else if (qcnt_q == QMAX) begin
                    state_d   = S_HIGH;
                    qcnt_d    = 4'd0;
                    rise_fire = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (!s_lvl) begin
                    if (NO_FILTER) begin
                        state_d   = S_LOW;
                        fall_fire = 1'b1;
                    end else begin
                        state_d = S_QUAL_LO;
                        qcnt_d  = 4'd1;
                    end
                end
            end
            S_QUAL_LO: begin
                if (s_lvl) begin
                    state_d = S_HIGH;
                    qcnt_d  = 4'd0;
                end else if (qcnt_q == QMAX) begin
                    state_d   = S_LOW;
                    qcnt_d    = 4'd0;
                    fall_fire = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_LOW;
                qcnt_d  = 4'd0;
            end
        endcase
    end

    logic level_out_q, level_out_d;
    logic rise_pulse_q, rise_pulse_d;
    logic fall_pulse_q, fall_pulse_d;

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        level_out_d  = (state_d == S_HIGH) || (state_d == S_QUAL_LO);
        rise_pulse_d = rise_fire;
        fall_pulse_d = fall_fire;
    end

    logic evt_fire;
`ifdef LATCH_EVENT_SYNC_FALL_EVT_EN
    assign evt_fire = rise_fire | fall_fire;
`else
    assign evt_fire = rise_fire;
`endif

    logic [CNT_W-1:0] seq_q, seq_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_edge_q, evt_edge_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic             overflow_q, overflow_d;

    // Record register: a handshake frees the slot in the same cycle a new event may claim it.
    // seq always advances so a dropped event shows up as a gap in evt_count.
    always_comb begin
        seq_d       = seq_q;
        evt_valid_d = evt_valid_q;
        evt_edge_d  = evt_edge_q;
        evt_count_d = evt_count_q;
        overflow_d  = overflow_q;
        if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        if (evt_fire) begin
            seq_d = seq_q + CNT_W'(1);
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_edge_d  = rise_fire ? EDGE_RISE : EDGE_FALL;
                evt_count_d = seq_d;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOW;
            qcnt_q       <= 4'd0;
            level_out_q  <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            seq_q        <= '0;
            evt_valid_q  <= 1'b0;
            evt_edge_q   <= 1'b0;
            evt_count_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            qcnt_q       <= qcnt_d;
            level_out_q  <= level_out_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            seq_q        <= seq_d;
            evt_valid_q  <= evt_valid_d;
            evt_edge_q   <= evt_edge_d;
            evt_count_q  <= evt_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign level_out  = level_out_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign evt_valid  = evt_valid_q;
    assign evt_edge   = evt_edge_q;
    assign evt_count  = evt_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_latch_event_sync.sv
// Directed bench for latch_event_sync with default parameters.
// Latency: expectations assume rise/fall strobes after edge 5 of a stable level.
// Backpressure: evt_ready is driven per scenario to exercise hold, drop and same-cycle reload.
module tb_latch_event_sync;

`ifdef LATCH_EVENT_SYNC_FALL_EVT_EN
    localparam int FALL_EN = 1;
`else
    localparam int FALL_EN = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       d_in;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_edge;
    logic [7:0] evt_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    latch_event_sync #(
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_edge  (evt_edge),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        d_in      = 1'b0;
        evt_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        d_in      = 1'b0;
        evt_ready = 1'b0;
        tick(2);
        n_tests++; if (level_out  !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b want 0", level_out); end
        n_tests++; if (rise_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_rise: got %b want 0", rise_pulse); end
        n_tests++; if (fall_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_fall: got %b want 0", fall_pulse); end
        n_tests++; if (evt_valid  !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        n_tests++; if (evt_edge   !== 1'b0) begin n_fail++; $display("FAIL reset_edge: got %b want 0", evt_edge); end
        n_tests++; if (evt_count  !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", evt_count); end
        n_tests++; if (overflow   !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rst_n = 1'b1;
        tick(3);
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", evt_valid); end
    endtask

    task automatic test_rise_latency();
        logic e;
        do_reset();
        d_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            e = (i == 5);
            n_tests++; if (rise_pulse !== e) begin n_fail++; $display("FAIL rise_lat edge%0d: got %b want %b", i, rise_pulse, e); end
            if (i == 4 || i == 5) begin
                n_tests++; if (level_out !== e) begin n_fail++; $display("FAIL rise_level edge%0d: got %b want %b", i, level_out, e); end
            end
        end
        n_tests++; if (level_out !== 1'b1) begin n_fail++; $display("FAIL rise_level_hold: got %b want 1", level_out); end
        n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL rise_valid: got %b want 1", evt_valid); end
        n_tests++; if (evt_edge  !== 1'b1) begin n_fail++; $display("FAIL rise_edge: got %b want 1", evt_edge); end
        n_tests++; if (evt_count !== 8'd1) begin n_fail++; $display("FAIL rise_count: got %0d want 1", evt_count); end
        n_tests++; if (overflow  !== 1'b0) begin n_fail++; $display("FAIL rise_ovf: got %b want 0", overflow); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL accept_valid: got %b want 0", evt_valid); end
    endtask

    task automatic test_glitch();
        do_reset();
        d_in = 1'b1;
        tick(2);
        d_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            n_tests++; if (rise_pulse !== 1'b0) begin n_fail++; $display("FAIL glitch_rise cyc%0d: got %b want 0", i, rise_pulse); end
        end
        n_tests++; if (level_out !== 1'b0) begin n_fail++; $display("FAIL glitch_level: got %b want 0", level_out); end
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", evt_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        evt_ready = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            d_in = 1'b1;
            tick(10);
            n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid r%0d: got %b want 1", r, evt_valid); end
            n_tests++; if (evt_count !== 8'd1) begin n_fail++; $display("FAIL ovf_hold_count r%0d: got %0d want 1", r, evt_count); end
            if (r == 1) begin
                n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_first: got %b want 0", overflow); end
            end else begin
                n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set r%0d: got %b want 1", r, overflow); end
            end
            d_in = 1'b0;
            tick(10);
        end
        evt_ready = 1'b1;
        tick(1);
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", evt_valid); end
        d_in = 1'b1;
        tick(6);
        n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_r4_valid: got %b want 1", evt_valid); end
        n_tests++; if (evt_count !== 8'(4 + 3 * FALL_EN)) begin n_fail++; $display("FAIL ovf_r4_count: got %0d want %0d", evt_count, 4 + 3 * FALL_EN); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        d_in = 1'b0;
        tick(10);
        evt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        evt_ready = 1'b0;
        d_in = 1'b1;
        tick(10);
        d_in = 1'b0;
        tick(10);
        n_tests++; if (evt_count !== 8'd1) begin n_fail++; $display("FAIL b2b_pending: got %0d want 1", evt_count); end
        d_in = 1'b1;
        tick(5);
        n_tests++; if (rise_pulse !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got %b want 0", rise_pulse); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        n_tests++; if (rise_pulse !== 1'b1) begin n_fail++; $display("FAIL b2b_pulse: got %b want 1", rise_pulse); end
        n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", evt_valid); end
        n_tests++; if (evt_count !== 8'(2 + FALL_EN)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", evt_count, 2 + FALL_EN); end
        n_tests++; if (overflow !== 1'(FALL_EN)) begin n_fail++; $display("FAIL b2b_ovf: got %b want %0d", overflow, FALL_EN); end
        tick(1);
        n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_valid: got %b want 1", evt_valid); end
        n_tests++; if (evt_edge !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_edge: got %b want 1", evt_edge); end
        d_in = 1'b0;
        tick(10);
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        do_reset();
        evt_ready = 1'b1;
        exp = 8'd0;
        for (int k = 1; k <= 256; k++) begin
            d_in = 1'b1;
            tick(6);
            exp = exp + 8'd1;
            if (k >= 254) begin
                n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid k%0d: got %b want 1", k, evt_valid); end
                n_tests++; if (evt_count !== exp) begin n_fail++; $display("FAIL wrap_count k%0d: got %0d want %0d", k, evt_count, exp); end
            end
            d_in = 1'b0;
            tick(14);
            exp = exp + 8'(FALL_EN);
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
        evt_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic e;
        do_reset();
        evt_ready = 1'b0;
        d_in = 1'b1;
        tick(10);
        d_in = 1'b0;
        tick(10);
        d_in = 1'b1;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (evt_valid  !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", evt_valid); end
        n_tests++; if (evt_count  !== 8'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", evt_count); end
        n_tests++; if (evt_edge   !== 1'b0) begin n_fail++; $display("FAIL areset_edge: got %b want 0", evt_edge); end
        n_tests++; if (level_out  !== 1'b0) begin n_fail++; $display("FAIL areset_level: got %b want 0", level_out); end
        n_tests++; if (rise_pulse !== 1'b0) begin n_fail++; $display("FAIL areset_rise: got %b want 0", rise_pulse); end
        n_tests++; if (overflow   !== 1'b0) begin n_fail++; $display("FAIL areset_ovf: got %b want 0", overflow); end
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            e = (i == 5);
            n_tests++; if (rise_pulse !== e) begin n_fail++; $display("FAIL areset_lat edge%0d: got %b want %b", i, rise_pulse, e); end
        end
        n_tests++; if (evt_count !== 8'd1) begin n_fail++; $display("FAIL areset_count_restart: got %0d want 1", evt_count); end
        d_in = 1'b0;
        tick(10);
    endtask

    task automatic test_fall();
        logic e;
        logic exp_edge;
        do_reset();
        evt_ready = 1'b1;
        d_in = 1'b1;
        tick(10);
        d_in = 1'b0;
        exp_edge = (FALL_EN == 1) ? 1'b0 : 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            e = (i == 5);
            n_tests++; if (fall_pulse !== e) begin n_fail++; $display("FAIL fall_lat edge%0d: got %b want %b", i, fall_pulse, e); end
            if (i == 5) begin
                n_tests++; if (level_out !== 1'b0) begin n_fail++; $display("FAIL fall_level: got %b want 0", level_out); end
                n_tests++; if (evt_valid !== 1'(FALL_EN)) begin n_fail++; $display("FAIL fall_valid: got %b want %0d", evt_valid, FALL_EN); end
                n_tests++; if (evt_edge !== exp_edge) begin n_fail++; $display("FAIL fall_edge: got %b want %b", evt_edge, exp_edge); end
                n_tests++; if (evt_count !== 8'(1 + FALL_EN)) begin n_fail++; $display("FAIL fall_count: got %0d want %0d", evt_count, 1 + FALL_EN); end
            end
        end
        evt_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        d_in      = 1'b0;
        evt_ready = 1'b0;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_fall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
